reaction_timer_mp: RTL and testbench

REACTION_TIMER_MP -- requirements
Module: reaction_timer_mp

---
 rtl/reaction_pkg.sv | 27 ++
 rtl/reaction_stats.sv | 70 +++++++
 rtl/reaction_timer_mp.sv | 211 +++++++++++++++++++++
 tb/tb_reaction_timer_mp.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction timer.
package reaction_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRun,
    StDone
  } state_e;

  // Galois LFSR for x^16 + x^14 + x^13 + x^11 + 1, shifting right
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam logic [1:0] StatLast = 2'b00;
  localparam logic [1:0] StatMin  = 2'b01;
  localparam logic [1:0] StatMax  = 2'b10;
  localparam logic [1:0] StatAvg  = 2'b11;

  // Reaction time in milliseconds
  typedef logic [9:0] time_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LfsrTaps) : (v >> 1);
  endfunction

endpackage

// File: rtl/reaction_stats.sv
// Circular history of winning times with last/min/max/average readout.
module reaction_stats
  import reaction_pkg::*;
#(
  parameter int unsigned HIST_DEPTH = 8  // power of two, at least 2
) (
  input  logic       clk_50M,
  input  logic       clear,
  input  logic       wr_en,
  input  time_t      wr_value,
  input  logic [1:0] stat_sel,
  output time_t      stat_value,
  output logic [3:0] stat_count
);

  localparam int unsigned PtrW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [3:0]  Full = 4'(HIST_DEPTH);

  time_t           hist_q [HIST_DEPTH];
  logic [PtrW-1:0] ptr_q;
  logic [3:0]      cnt_q;

  time_t       min_v, max_v, last_v;
  logic [13:0] sum_v, avg_v;

  // History write: pointer wraps naturally, count saturates once full
  always_ff @(posedge clk_50M) begin
    if (clear) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (wr_en) begin
      hist_q[ptr_q] <= wr_value;
      ptr_q         <= ptr_q + 1'b1;
      if (cnt_q != Full) cnt_q <= cnt_q + 4'd1;
    end
  end

  // Statistics over the valid slots; slots 0..cnt-1 are valid until the first wrap
  always_comb begin
    min_v = '1;
    max_v = '0;
    sum_v = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (i < int'(cnt_q)) begin
        if (hist_q[i] < min_v) min_v = hist_q[i];
        if (hist_q[i] > max_v) max_v = hist_q[i];
        sum_v = sum_v + 14'(hist_q[i]);
      end
    end
    last_v = hist_q[ptr_q - 1'b1];
    avg_v  = (cnt_q == 4'd0) ? '0 : sum_v / 14'(cnt_q);
  end

  // Statistic select
  always_comb begin
    stat_value = '0;
    if (cnt_q != 4'd0) begin
      unique case (stat_sel)
        StatLast: stat_value = last_v;
        StatMin:  stat_value = min_v;
        StatMax:  stat_value = max_v;
        StatAvg:  stat_value = avg_v[9:0];
        default:  stat_value = '0;
      endcase
    end
  end

  assign stat_count = cnt_q;

endmodule

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction timer: random delay, LED stimulus, per-player timing,
// foul detection, winner selection and result history.
module reaction_timer_mp
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned N_PLAYERS  = 2,
  parameter int unsigned MAX_COUNT  = 999,
  parameter int unsigned DMIN_MS    = 2000,
  parameter int unsigned DMAX_MS    = 6000,
  parameter int unsigned HIST_DEPTH = 8
) (
  input  logic                    clk_50M,
  input  logic                    clear,
  input  logic                    start,
  input  logic [N_PLAYERS-1:0]    stop,
  input  logic [1:0]              stat_sel,
  output logic                    LED,
  output logic                    busy,
  output logic [N_PLAYERS*10-1:0] result,
  output logic [N_PLAYERS-1:0]    foul,
  output logic [2:0]              winner,
  output logic                    winner_valid,
  output logic                    tie,
  output logic [9:0]              stat_value,
  output logic [3:0]              stat_count
);

  localparam int unsigned TickCyc = CLK_HZ / 1000;
  localparam int unsigned PrescW  = (TickCyc > 1) ? $clog2(TickCyc) : 1;
  localparam int unsigned DRange  = DMAX_MS - DMIN_MS + 1;
  localparam time_t       MaxTime = time_t'(MAX_COUNT);
  localparam logic [12:0] DMin    = 13'(DMIN_MS);

  state_e state_q, state_d;

  logic [PrescW-1:0]            presc_q, presc_d;
  logic [15:0]                  lfsr_q;
  logic [12:0]                  delay_q, delay_d, ms_q, ms_d;
  time_t                        count_q, count_d;
  time_t [N_PLAYERS-1:0]        result_q, result_d;
  logic [N_PLAYERS-1:0]         foul_q, foul_d, stopped_q, stopped_d;
  logic [2:0]                   winner_q, winner_d;
  logic                         winner_valid_q, winner_valid_d, tie_q, tie_d;

  logic                 tick, expire, sat, all_fouled, all_stopped;
  logic [N_PLAYERS-1:0] wait_foul, cap;
  logic                 start_round, enter_timed, enter_done, hist_wr;
  logic                 win_found, win_tie;
  logic [2:0]           win_idx;
  time_t                best;

  // Round events derived from current state and inputs only
  always_comb begin
    tick        = ((state_q == StWait) || (state_q == StRun)) &&
                  (presc_q == PrescW'(TickCyc - 1));
    expire      = (state_q == StWait) && tick && ((ms_q + 13'd1) == delay_q);
    wait_foul   = (state_q == StWait) ? stop : '0;
    cap         = (state_q == StRun) ? (stop & ~foul_q & ~stopped_q) : '0;
    all_fouled  = &(foul_q | wait_foul);
    all_stopped = &(foul_q | stopped_q | cap);
    sat         = (count_q == MaxTime);
  end

  // State register
  always_ff @(posedge clk_50M) begin
    if (clear) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state; a foul on the expiry cycle wins because WAIT stays until then
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StWait;
      StWait: begin
        if (all_fouled)  state_d = StDone;
        else if (expire) state_d = StRun;
      end
      StRun:   if (all_stopped || sat) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    LED  = (state_q == StRun);
    busy = (state_q == StWait) || (state_q == StRun);
  end

  // Timing and per-player capture datapath
  always_comb begin
    start_round = start && ((state_q == StIdle) || (state_q == StDone));
    enter_timed = (state_d != state_q) && ((state_d == StWait) || (state_d == StRun));
    enter_done  = (state_q != StDone) && (state_d == StDone);

    presc_d = presc_q;
    if ((state_q == StWait) || (state_q == StRun)) presc_d = tick ? '0 : presc_q + 1'b1;
    if (enter_timed) presc_d = '0;

    ms_d = ms_q;
    if ((state_q == StWait) && tick) ms_d = ms_q + 13'd1;
    if (enter_timed) ms_d = '0;

    count_d = count_q;
    if ((state_q == StRun) && tick && !sat) count_d = count_q + 10'd1;
    if (enter_timed) count_d = '0;

    delay_d = delay_q;
    if (start_round) delay_d = DMin + 13'(lfsr_q % 16'(DRange));

    foul_d    = foul_q | wait_foul;
    stopped_d = stopped_q | cap;
    result_d  = result_q;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (cap[i]) result_d[i] = count_q;
      else if (enter_done && !foul_d[i] && !stopped_d[i]) result_d[i] = MaxTime;
    end

    if (start_round) begin
      foul_d    = '0;
      stopped_d = '0;
      result_d  = '0;
    end
  end

  // Fastest non-fouled player; lowest index wins on equal times
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    best      = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (!foul_d[i] && (!win_found || (result_d[i] < best))) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        best      = result_d[i];
      end
    end
    win_tie = 1'b0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (win_found && !foul_d[i] && (3'(i) != win_idx) && (result_d[i] == best)) begin
        win_tie = 1'b1;
      end
    end
  end

  // Winner flags update on DONE entry and clear at the start of a round
  always_comb begin
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    tie_d          = tie_q;
    if (start_round) begin
      winner_valid_d = 1'b0;
      tie_d          = 1'b0;
    end
    if (enter_done) begin
      winner_d       = win_idx;
      winner_valid_d = win_found;
      tie_d          = win_tie;
    end
    hist_wr = enter_done && win_found;
  end

  // Datapath registers; the LFSR free-runs regardless of state
  always_ff @(posedge clk_50M) begin
    if (clear) begin
      presc_q        <= '0;
      lfsr_q         <= LfsrSeed;
      delay_q        <= '0;
      ms_q           <= '0;
      count_q        <= '0;
      result_q       <= '0;
      foul_q         <= '0;
      stopped_q      <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      tie_q          <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      lfsr_q         <= lfsr_step(lfsr_q);
      delay_q        <= delay_d;
      ms_q           <= ms_d;
      count_q        <= count_d;
      result_q       <= result_d;
      foul_q         <= foul_d;
      stopped_q      <= stopped_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      tie_q          <= tie_d;
    end
  end

  assign result       = result_q;
  assign foul         = foul_q;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign tie          = tie_q;

  reaction_stats #(
    .HIST_DEPTH (HIST_DEPTH)
  ) u_stats (
    .clk_50M    (clk_50M),
    .clear      (clear),
    .wr_en      (hist_wr),
    .wr_value   (best),
    .stat_sel   (stat_sel),
    .stat_value (stat_value),
    .stat_count (stat_count)
  );

endmodule

// File: tb/tb_reaction_timer_mp.sv
// Scoreboard bench for reaction_timer_mp: rounds push expected DONE results,
// a monitor compares them whenever busy falls.
module tb_reaction_timer_mp;

  logic        clk_50M = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  stop = 2'b00;
  logic [1:0]  stat_sel = 2'b00;
  logic        LED, busy;
  logic [19:0] result;
  logic [1:0]  foul;
  logic [2:0]  winner;
  logic        winner_valid, tie;
  logic [9:0]  stat_value;
  logic [3:0]  stat_count;

  typedef struct packed {
    logic [19:0] result;
    logic [1:0]  foul;
    logic [2:0]  winner;
    logic        wv;
    logic        tie;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          hist_n = 0;
  logic        busy_prev = 1'b0;
  logic [15:0] m_lfsr = 16'h0000;

  reaction_timer_mp #(
    .CLK_HZ     (4000),
    .N_PLAYERS  (2),
    .MAX_COUNT  (999),
    .DMIN_MS    (2),
    .DMAX_MS    (6),
    .HIST_DEPTH (8)
  ) dut (
    .clk_50M      (clk_50M),
    .clear        (clear),
    .start        (start),
    .stop         (stop),
    .stat_sel     (stat_sel),
    .LED          (LED),
    .busy         (busy),
    .result       (result),
    .foul         (foul),
    .winner       (winner),
    .winner_valid (winner_valid),
    .tie          (tie),
    .stat_value   (stat_value),
    .stat_count   (stat_count)
  );

  always #5 clk_50M = ~clk_50M;

  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    logic fb;
    fb = v[0];
    v  = v >> 1;
    if (fb) v = v ^ 16'hB400;
    return v;
  endfunction

  // Reference LFSR tracking the polynomial from the known seed
  always @(posedge clk_50M) m_lfsr <= clear ? 16'hACE1 : ref_lfsr(m_lfsr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  // Monitor: every round end (busy falling) is compared with the oldest expectation
  always @(negedge clk_50M) begin
    if (busy_prev && !busy) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_round_end: got busy fall, expected none queued");
      end else begin
        mon_e = sb_q.pop_front();
        check("result", 32'(result), 32'(mon_e.result));
        check("foul", 32'(foul), 32'(mon_e.foul));
        check("winner", 32'(winner), 32'(mon_e.winner));
        check("winner_valid", 32'(winner_valid), 32'(mon_e.wv));
        check("tie", 32'(tie), 32'(mon_e.tie));
        check("stat_count", 32'(stat_count), 32'(mon_e.cnt));
      end
    end
    busy_prev = busy;
  end

  // s0/s1: count at which the player stops in RUN, -1 never, -2 foul in WAIT
  task automatic run_round(input int s0, input int s1, input logic [9:0] r0,
                           input logic [9:0] r1, input logic [1:0] f, input logic [2:0] w,
                           input logic wv, input logic t, input bit meas);
    exp_t        e;
    int          k;
    int          d_exp;
    logic [1:0]  fw;
    if (wv) hist_n = (hist_n < 8) ? hist_n + 1 : 8;
    e.result = {r1, r0};
    e.foul   = f;
    e.winner = w;
    e.wv     = wv;
    e.tie    = t;
    e.cnt    = 4'(hist_n);
    sb_q.push_back(e);

    d_exp = 2 + int'(m_lfsr % 16'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    k  = 0;
    fw = {s1 == -2, s0 == -2};
    if (fw != 2'b00) begin
      stop = fw;
      step();
      stop = 2'b00;
      k = 1;
    end
    if (fw != 2'b11) begin
      while (!LED && k < 40) begin
        step();
        k++;
      end
      check("led_rise", 32'(LED), 32'd1);
      if (meas) check("delay_cycles", k, 4 * d_exp);
    end else begin
      check("led_low_all_foul", 32'(LED), 32'd0);
    end

    k = 0;
    while (busy && k < 5000) begin
      stop[0] = (s0 >= 0) && (k == 4 * s0);
      stop[1] = (s1 >= 0) && (k == 4 * s1);
      start   = (k == 2);
      step();
      stop  = 2'b00;
      start = 1'b0;
      k++;
    end
    check("round_end", 32'(busy), 32'd0);
    check("led_fall", 32'(LED), 32'd0);
    stop = 2'b11;
    step();
    stop = 2'b00;
    check("done_stop_ignored", 32'(result), 32'({r1, r0}));
  endtask

  initial begin
    exp_t ez;
    int   k;
    repeat (3) step();
    clear = 1'b0;
    check("rst_led", 32'(LED), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_foul", 32'(foul), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_wv", 32'(winner_valid), 32'd0);
    check("rst_tie", 32'(tie), 32'd0);
    check("rst_stat_count", 32'(stat_count), 32'd0);
    check("rst_stat_value", 32'(stat_value), 32'd0);

    run_round(150, 210, 10'd150, 10'd210, 2'b00, 3'd0, 1'b1, 1'b0, 1'b1);
    run_round(120, -2, 10'd120, 10'd0, 2'b10, 3'd0, 1'b1, 1'b0, 1'b0);
    run_round(-2, -2, 10'd0, 10'd0, 2'b11, 3'd0, 1'b0, 1'b0, 1'b0);
    run_round(-1, -1, 10'd999, 10'd999, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0);
    run_round(300, 250, 10'd300, 10'd250, 2'b00, 3'd1, 1'b1, 1'b0, 1'b0);
    run_round(77, 77, 10'd77, 10'd77, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0);

    // Empty the history, then nine rounds with winning times 100..900
    clear = 1'b1;
    step();
    clear  = 1'b0;
    hist_n = 0;
    check("hist_cleared", 32'(stat_count), 32'd0);
    check("stat_empty", 32'(stat_value), 32'd0);
    for (int t = 100; t <= 900; t += 100) begin
      run_round(t, t + 1, 10'(t), 10'(t + 1), 2'b00, 3'd0, 1'b1, 1'b0, 1'b0);
    end
    check("hist_count_sat", 32'(stat_count), 32'd8);
    stat_sel = 2'b00; #1 check("stat_last", 32'(stat_value), 32'd900);
    stat_sel = 2'b01; #1 check("stat_min", 32'(stat_value), 32'd200);
    stat_sel = 2'b10; #1 check("stat_max", 32'(stat_value), 32'd900);
    stat_sel = 2'b11; #1 check("stat_avg", 32'(stat_value), 32'd550);

    // clear together with a stop in RUN aborts the round and empties the history
    ez     = '0;
    hist_n = 0;
    sb_q.push_back(ez);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!LED && k < 40) begin
      step();
      k++;
    end
    check("led_rise_abort", 32'(LED), 32'd1);
    repeat (20) step();
    clear = 1'b1;
    stop  = 2'b01;
    step();
    clear = 1'b0;
    stop  = 2'b00;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_led", 32'(LED), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_stat_count", 32'(stat_count), 32'd0);

    repeat (3) step();
    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
